bin_decode_engine: RTL

BIN_DECODE_ENGINE -- requirements
Module: bin_decode_engine

---
 rtl/bin_decode_engine_if.sv | 27 ++
 rtl/bin_decode_engine.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bin_decode_engine_if.sv
// Bitstream, bin-request and LPS-calculator signals of the bin decode engine.
// master = requester/bitstream side, slave = engine.
interface bin_decode_engine_if;
   logic       init;
   logic [7:0] bs_data;
   logic       bs_valid;
   logic       bs_ready;
   logic       bin_req;
   logic [7:0] bin_state;
   logic       bin_ready;
   logic [8:0] lps_range;
   logic [7:0] lps_state;
   logic [7:0] lps_in;
   logic       bin_valid;
   logic       bin_val;
   logic       err;

   modport master (
      output init, bs_data, bs_valid, bin_req, bin_state, lps_in,
      input  bs_ready, bin_ready, lps_range, lps_state, bin_valid, bin_val, err
   );

   modport slave (
      input  init, bs_data, bs_valid, bin_req, bin_state, lps_in,
      output bs_ready, bin_ready, lps_range, lps_state, bin_valid, bin_val, err
   );
endinterface

// File: rtl/bin_decode_engine.sv
// Arithmetic bin decoder: 9-bit range/offset engine fed MSB-first from a one-byte bit buffer,
// with an external LPS range lookup driven combinationally from lps_range/lps_state.
module bin_decode_engine (
   input  logic                 clk,
   input  logic                 rst_n,
   bin_decode_engine_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, FILL, READY, RENORM} state_t;

   state_t     state, state_nx;
   logic [8:0] range, range_nx;
   logic [8:0] offset, offset_nx;
   logic [7:0] bbuf, bbuf_nx;
   logic [3:0] bcnt, bcnt_nx;
   logic [3:0] fcnt, fcnt_nx;
   logic       err_q, err_nx;
   logic       valid_q, valid_nx;
   logic       val_q, val_nx;

   logic       bit_avail;
   logic       consume;
   logic [8:0] rmps;
   logic       lps_hit;
   logic [8:0] sh_range;
   logic [8:0] sh_offset;
   logic [8:0] bin_range;
   logic [8:0] bin_offset;

   assign bit_avail  = (bcnt != 4'd0);
   assign rmps       = range - {1'b0, bus.lps_in};
   assign lps_hit    = (offset >= rmps);
   assign sh_range   = {range[7:0], 1'b0};
   assign sh_offset  = {offset[7:0], bbuf[7]};
   assign bin_range  = lps_hit ? {1'b0, bus.lps_in} : rmps;
   assign bin_offset = lps_hit ? (offset - rmps) : offset;

   assign bus.bs_ready  = (bcnt == 4'd0);
   assign bus.bin_ready = (state == READY);
   assign bus.lps_range = range;
   assign bus.lps_state = bus.bin_state;
   assign bus.bin_valid = valid_q;
   assign bus.bin_val   = val_q;
   assign bus.err       = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         range   <= '0;
         offset  <= '0;
         bbuf    <= '0;
         bcnt    <= '0;
         fcnt    <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         val_q   <= 1'b0;
      end else begin
         state   <= state_nx;
         range   <= range_nx;
         offset  <= offset_nx;
         bbuf    <= bbuf_nx;
         bcnt    <= bcnt_nx;
         fcnt    <= fcnt_nx;
         err_q   <= err_nx;
         valid_q <= valid_nx;
         val_q   <= val_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      range_nx  = range;
      offset_nx = offset;
      fcnt_nx   = fcnt;
      err_nx    = err_q;
      valid_nx  = 1'b0;
      val_nx    = val_q;
      consume   = 1'b0;

      // init restarts the slice from any state but leaves the bit buffer intact
      if (bus.init) begin
         state_nx  = FILL;
         range_nx  = 9'd510;
         offset_nx = '0;
         fcnt_nx   = '0;
         err_nx    = 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (bit_avail) begin
                  consume   = 1'b1;
                  offset_nx = sh_offset;
                  fcnt_nx   = fcnt + 4'd1;
                  if (fcnt == 4'd8) begin
                     state_nx = READY;
                     if (sh_offset >= 9'd510) err_nx = 1'b1;
                  end
               end
            end
            READY: begin
               if (bus.bin_req) begin
                  valid_nx  = 1'b1;
                  val_nx    = lps_hit ? ~bus.bin_state[7] : bus.bin_state[7];
                  range_nx  = bin_range;
                  offset_nx = bin_offset;
                  if (!bin_range[8]) state_nx = RENORM;
                  else if (bin_offset >= bin_range) err_nx = 1'b1;
               end
            end
            RENORM: begin
               if (bit_avail) begin
                  consume   = 1'b1;
                  range_nx  = sh_range;
                  offset_nx = sh_offset;
                  if (sh_range[8]) begin
                     state_nx = READY;
                     if (sh_offset >= sh_range) err_nx = 1'b1;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // consume requires bcnt > 0 and load requires bcnt == 0, so they never collide
   always_comb begin
      bbuf_nx = bbuf;
      bcnt_nx = bcnt;
      if (consume) begin
         bbuf_nx = {bbuf[6:0], 1'b0};
         bcnt_nx = bcnt - 4'd1;
      end else if (bus.bs_valid && (bcnt == 4'd0)) begin
         bbuf_nx = bus.bs_data;
         bcnt_nx = 4'd8;
      end
   end

endmodule
